// File: rtl/cmv300_capture_sequencer_if.sv
// Signal bundle between the capture sequencer and its surroundings
// (SPI master handshake, sensor pins, host pipe FIFO, status).
interface cmv300_capture_sequencer_if;
    logic       init_start;
    logic       cfg_start;
    logic       cfg_done;
    logic       capture_start;
    logic       SYS_RES_N;
    logic       FRAME_REQ;
    logic       Line_valid;
    logic       Data_valid;
    logic [7:0] D;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       fifo_full;
    logic       ready;
    logic       frame_done;
    logic       overflow;
    logic       timeout;

    modport master (
        input  init_start, cfg_done, capture_start, Line_valid, Data_valid, D, fifo_full,
        output cfg_start, SYS_RES_N, FRAME_REQ, pix_valid, pix_data, ready, frame_done,
               overflow, timeout
    );

    modport slave (
        output init_start, cfg_done, capture_start, Line_valid, Data_valid, D, fifo_full,
        input  cfg_start, SYS_RES_N, FRAME_REQ, pix_valid, pix_data, ready, frame_done,
               overflow, timeout
    );
endinterface

// File: rtl/cmv300_capture_sequencer.sv
// CMV300 sequencer: power-up reset, config handoff, frame request and
// capture of one 8-bit frame into the host pipe FIFO.
module cmv300_capture_sequencer #(
    parameter int unsigned H_PIXELS      = 648,
    parameter int unsigned V_LINES       = 488,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned WAKE_CYCLES   = 1000,
    parameter int unsigned FRAME_REQ_CYC = 4,
    parameter int unsigned TIMEOUT_CYC   = 1048576
) (
    input  logic                          FSM_Clk,
    input  logic                          Reset_n,
    cmv300_capture_sequencer_if.master    cam_if
);

    // One shared phase counter serves RST, WAKE, FREQ and WAIT.
    localparam int unsigned M1      = (RESET_CYCLES > WAKE_CYCLES) ? RESET_CYCLES : WAKE_CYCLES;
    localparam int unsigned M2      = (M1 > FRAME_REQ_CYC) ? M1 : FRAME_REQ_CYC;
    localparam int unsigned CNT_MAX = (M2 > TIMEOUT_CYC) ? M2 : TIMEOUT_CYC;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned PW      = $clog2(H_PIXELS + 1);
    localparam int unsigned LW      = $clog2(V_LINES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_WAKE, S_CFG, S_READY, S_FREQ, S_WAIT, S_CAP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [PW-1:0]   r_pix_cnt, w_pix_cnt_nxt;
    logic [LW-1:0]   r_line_cnt, w_line_cnt_nxt;
    logic            r_lv_q;
    logic            r_pix_valid, w_pix_valid_nxt;
    logic [7:0]      r_pix_data, w_pix_data_nxt;
    logic            r_cfg_start, w_cfg_start_nxt;
    logic            r_frame_done, w_frame_done_nxt;
    logic            r_overflow, w_overflow_nxt;
    logic            r_timeout, w_timeout_nxt;
    logic            w_capture;
    logic            w_lv_fall;

    assign w_lv_fall = r_lv_q & ~cam_if.Line_valid;

    always_ff @(posedge FSM_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_lv_q       <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_pix_data   <= '0;
            r_cfg_start  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pix_cnt    <= w_pix_cnt_nxt;
            r_line_cnt   <= w_line_cnt_nxt;
            r_lv_q       <= cam_if.Line_valid;
            r_pix_valid  <= w_pix_valid_nxt;
            r_pix_data   <= w_pix_data_nxt;
            r_cfg_start  <= w_cfg_start_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_overflow   <= w_overflow_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_pix_cnt_nxt    = r_pix_cnt;
        w_line_cnt_nxt   = r_line_cnt;
        w_pix_valid_nxt  = 1'b0;
        w_pix_data_nxt   = r_pix_data;
        w_cfg_start_nxt  = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_overflow_nxt   = r_overflow;
        w_timeout_nxt    = r_timeout;
        w_capture        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cam_if.init_start) w_state_nxt = S_RST;
            end
            S_RST: begin
                if (r_cnt == CW'(RESET_CYCLES - 1)) w_state_nxt = S_WAKE;
                else                                w_cnt_nxt   = r_cnt + CW'(1);
            end
            S_WAKE: begin
                if (r_cnt == CW'(WAKE_CYCLES - 1)) begin
                    w_state_nxt     = S_CFG;
                    w_cfg_start_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_CFG: begin
                if (cam_if.cfg_done) w_state_nxt = S_READY;
            end
            S_READY: begin
                if (cam_if.init_start) begin
                    w_state_nxt = S_RST;
                end else if (cam_if.capture_start) begin
                    w_state_nxt    = S_FREQ;
                    w_overflow_nxt = 1'b0;
                    w_timeout_nxt  = 1'b0;
                end
            end
            S_FREQ: begin
                if (r_cnt == CW'(FRAME_REQ_CYC - 1)) begin
                    w_state_nxt    = S_WAIT;
                    w_pix_cnt_nxt  = '0;
                    w_line_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                // Data arriving on the final timeout cycle still starts the capture.
                if (cam_if.Data_valid) begin
                    w_state_nxt = S_CAP;
                    w_capture   = 1'b1;
                end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt   = S_READY;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_CAP: begin
                w_capture = cam_if.Data_valid;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_capture && (r_pix_cnt < PW'(H_PIXELS))) begin
            w_pix_cnt_nxt = r_pix_cnt + PW'(1);
            if (cam_if.fifo_full) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_pix_valid_nxt = 1'b1;
                w_pix_data_nxt  = cam_if.D;
            end
        end

        // End of line restarts the pixel count; the last line closes the frame.
        if ((r_state == S_CAP) && w_lv_fall) begin
            w_pix_cnt_nxt  = '0;
            w_line_cnt_nxt = r_line_cnt + LW'(1);
            if (r_line_cnt == LW'(V_LINES - 1)) begin
                w_state_nxt      = S_READY;
                w_frame_done_nxt = 1'b1;
            end
        end

        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    assign cam_if.SYS_RES_N  = (r_state != S_IDLE) && (r_state != S_RST);
    assign cam_if.FRAME_REQ  = (r_state == S_FREQ);
    assign cam_if.ready      = (r_state == S_READY);
    assign cam_if.cfg_start  = r_cfg_start;
    assign cam_if.pix_valid  = r_pix_valid;
    assign cam_if.pix_data   = r_pix_data;
    assign cam_if.frame_done = r_frame_done;
    assign cam_if.overflow   = r_overflow;
    assign cam_if.timeout    = r_timeout;

endmodule

// File: tb/tb_cmv300_capture_sequencer.sv
// Bench for cmv300_capture_sequencer: directed sequencing checks plus
// randomized frames compared against a pixel-list reference model.
module tb_cmv300_capture_sequencer;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 4;
    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       exp_ovf;
    int         fd_cnt = 0;

    cmv300_capture_sequencer_if cam();

    cmv300_capture_sequencer #(
        .H_PIXELS(H), .V_LINES(V), .RESET_CYCLES(16), .WAKE_CYCLES(1000),
        .FRAME_REQ_CYC(4), .TIMEOUT_CYC(TO)
    ) dut (
        .FSM_Clk(clk),
        .Reset_n(rst_n),
        .cam_if(cam.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cam.pix_valid === 1'b1) got_q.push_back(cam.pix_data);
        if (cam.frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sysres"}, 32'(cam.SYS_RES_N), 0);
        chk({tag, "_freq"}, 32'(cam.FRAME_REQ), 0);
        chk({tag, "_cfgst"}, 32'(cam.cfg_start), 0);
        chk({tag, "_pv"}, 32'(cam.pix_valid), 0);
        chk({tag, "_pd"}, 32'(cam.pix_data), 0);
        chk({tag, "_ready"}, 32'(cam.ready), 0);
        chk({tag, "_fd"}, 32'(cam.frame_done), 0);
        chk({tag, "_ovf"}, 32'(cam.overflow), 0);
        chk({tag, "_tmo"}, 32'(cam.timeout), 0);
    endtask

    // Pulses capture_start from READY and measures the FRAME_REQ width.
    task automatic start_capture(input string tag);
        int n;
        cam.capture_start = 1'b1;
        tick();
        cam.capture_start = 1'b0;
        n = 0;
        while (cam.FRAME_REQ === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk({tag, "_freq_width"}, 32'(n), 4);
        chk({tag, "_ovf_clr"}, 32'(cam.overflow), 0);
        chk({tag, "_tmo_clr"}, 32'(cam.timeout), 0);
    endtask

    // Walks through init: SYS_RES_N low period, wake time, cfg handoff.
    task automatic run_init(input string tag, input bit poke_capture_in_cfg);
        int n;
        n = 0;
        while (cam.SYS_RES_N !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_res_low"}, 32'(n), 16);
        n = 0;
        while (cam.cfg_start !== 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        chk({tag, "_wake"}, 32'(n), 1000);
        tick();
        chk({tag, "_cfg_pulse"}, 32'(cam.cfg_start), 0);
        if (poke_capture_in_cfg) begin
            cam.capture_start = 1'b1;
            tick();
            cam.capture_start = 1'b0;
            tick();
            chk({tag, "_cap_in_cfg_freq"}, 32'(cam.FRAME_REQ), 0);
            chk({tag, "_cap_in_cfg_rdy"}, 32'(cam.ready), 0);
        end
        cam.cfg_done = 1'b1;
        tick();
        cam.cfg_done = 1'b0;
        chk({tag, "_ready"}, 32'(cam.ready), 1);
        chk({tag, "_sysres_hi"}, 32'(cam.SYS_RES_N), 1);
    endtask

    // mode 0: D=line*16+pix; mode 1: same with fifo_full on pixels 4..6; mode 2: random.
    task automatic send_frame(input int mode, input string tag);
        int g;
        int np;
        int n;
        logic full;
        got_q.delete();
        exp_q.delete();
        exp_ovf = 1'b0;
        fd_cnt = 0;
        g = 0;
        if (mode == 2) repeat ($urandom_range(0, 20)) tick();
        for (int l = 0; l < int'(V); l++) begin
            cam.Line_valid = 1'b1;
            np = (mode == 2) ? int'(H) + int'($urandom_range(0, 2)) : int'(H);
            for (int p = 0; p < np; p++) begin
                if (mode == 2 && $urandom_range(0, 3) == 0) begin
                    cam.Data_valid = 1'b0;
                    cam.fifo_full = 1'b0;
                    tick();
                end
                cam.Data_valid = 1'b1;
                cam.D = (mode == 2) ? 8'($urandom) : 8'(l * 16 + p);
                full = (mode == 1) ? (g >= 4 && g <= 6) :
                       (mode == 2) ? ($urandom_range(0, 4) == 0) : 1'b0;
                cam.fifo_full = full;
                if (p < int'(H)) begin
                    if (full) exp_ovf = 1'b1;
                    else      exp_q.push_back(cam.D);
                end
                g++;
                tick();
            end
            cam.Line_valid = 1'b0;
            cam.Data_valid = 1'b0;
            cam.fifo_full = 1'b0;
            tick();
            if (l != int'(V) - 1) repeat ($urandom_range(1, 3)) tick();
        end
        n = 0;
        while (cam.ready !== 1'b1 && n < 5) begin
            n++;
            tick();
        end
        chk({tag, "_ready"}, 32'(cam.ready), 1);
        tick();
        tick();
        chk({tag, "_frame_done_cnt"}, 32'(fd_cnt), 1);
        chk({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_pix"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_overflow"}, 32'(cam.overflow), 32'(exp_ovf));
        chk({tag, "_timeout"}, 32'(cam.timeout), 0);
    endtask

    initial begin
        int n;
        cam.init_start = 1'b0;
        cam.cfg_done = 1'b0;
        cam.capture_start = 1'b0;
        cam.Line_valid = 1'b0;
        cam.Data_valid = 1'b0;
        cam.D = '0;
        cam.fifo_full = 1'b0;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_sysres", 32'(cam.SYS_RES_N), 0);
        chk("idle_ready", 32'(cam.ready), 0);

        // cfg_done outside CFG is ignored
        cam.cfg_done = 1'b1;
        tick();
        cam.cfg_done = 1'b0;
        tick();
        chk("idle_cfgdone_ready", 32'(cam.ready), 0);

        cam.init_start = 1'b1;
        tick();
        cam.init_start = 1'b0;
        run_init("init", 1'b1);

        start_capture("cap0");
        send_frame(0, "frame_seq");

        start_capture("cap1");
        send_frame(1, "frame_full");
        chk("frame_full_13", 32'(got_q.size()), 13);

        start_capture("cap2");
        got_q.delete();
        n = 0;
        while (cam.timeout !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("tmo_cycle", 32'(n), TO);
        chk("tmo_ready", 32'(cam.ready), 1);
        chk("tmo_nowrites", 32'(got_q.size()), 0);

        for (int f = 0; f < 4; f++) begin
            start_capture("capr");
            send_frame(2, "frame_rand");
        end

        // simultaneous init_start and capture_start: init wins
        cam.init_start = 1'b1;
        cam.capture_start = 1'b1;
        tick();
        cam.init_start = 1'b0;
        cam.capture_start = 1'b0;
        chk("both_sysres", 32'(cam.SYS_RES_N), 0);
        chk("both_freq", 32'(cam.FRAME_REQ), 0);
        chk("both_ready", 32'(cam.ready), 0);
        run_init("reinit", 1'b0);

        // asynchronous reset in the middle of a capture
        start_capture("cap_rst");
        cam.Line_valid = 1'b1;
        cam.Data_valid = 1'b1;
        cam.D = 8'hA5;
        repeat (3) tick();
        chk("midcap_pv", 32'(cam.pix_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midcap_rst");
        cam.Line_valid = 1'b0;
        cam.Data_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_sysres", 32'(cam.SYS_RES_N), 0);
        chk("post_rst_ready", 32'(cam.ready), 0);
        chk("post_rst_freq", 32'(cam.FRAME_REQ), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
